weight_column_loader: RTL and testbench
=======================================

# weight_column_loader

Write-side companion to `weightRAM`. It accepts a serial stream of fixed-point weights, one element per beat under a valid/ready handshake. It assembles each element into a full-width column word and commits one column per write cycle through `colAddressWrite`/`writeEn`. It replaces the behavioural column-by-column loading currently done in benches, so that `gate` weight memories (X: ROWS×INPUT_SZ, Y: ROWS×HIDDEN_SZ) can be loaded from a host/DMA stream in hardware.

## Interface
- `ROWS`, 32, elements per column (= HIDDEN_SZ); word width of the target RAM is ROWS*BITWIDTH.
- `COLS`, 4, number of columns to load (= INPUT_SZ for X RAM, HIDDEN_SZ for Y RAM).
- `QN`, 7, integer bits of the fixed-point format.
- `QM`, 10, fractional bits of the fixed-point format.
- Derived: BITWIDTH = QN+QM+1 (18); LAYER_BITWIDTH = ROWS*BITWIDTH; ADDR_BITWIDTH = max(1, clog2(COLS)).

- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `startLoad`  in  1  request a full load of COLS columns; sampled only in IDLE.
- `dataIn`  in  BITWIDTH  weight element, two's complement Q(QN).(QM), passed through bit-exact.
- `dataValid`  in  1  `dataIn` is valid this cycle.
- `dataReady`  out  1  block accepts `dataIn` this cycle; a beat transfers when `dataValid && dataReady`.
- `weightMemInput`  out  LAYER_BITWIDTH  assembled column; element row r at bits [r*BITWIDTH +: BITWIDTH].
- `colAddressWrite`  out  ADDR_BITWIDTH  column address of the current write.
- `writeEn`  out  1  one-cycle write strobe to `weightRAM`.
- `busy`  out  1  high in every state except IDLE.
- `loadDone`  out  1  one-cycle pulse after the final column is written.

## Operation
- States: IDLE, FILL, WRITE, DONE. The state and all outputs are registered.
- IDLE: `dataReady`=0, `busy`=0. If `startLoad`=1, next state is FILL, with rowCount=0 and colCount=0.
- FILL: `dataReady`=1, `busy`=1. On each accepted beat:
  - `dataIn` is stored into row slot rowCount of the column register.
  - rowCount increments.
  - On the beat where rowCount==ROWS-1, rowCount wraps to 0 and next state is WRITE.
  - Cycles with `dataValid`=0 hold all state (gaps are allowed, unlimited length).
- WRITE: exactly one cycle.
  - `writeEn`=1, `colAddressWrite`=colCount, `weightMemInput` holds the complete column, `dataReady`=0.
  - If colCount==COLS-1, next state is DONE; otherwise colCount increments and next state is FILL.
- DONE: exactly one cycle, `loadDone`=1, `busy`=1, then IDLE.
- `startLoad` outside IDLE is ignored and is not queued.
- `dataValid` in IDLE/WRITE/DONE is ignored; no beat transfers because `dataReady`=0.
- Column order is ascending, 0..COLS-1. Row order within a column is ascending, 0..ROWS-1.
- No arithmetic is performed on data; values are stored and forwarded unmodified. Sign is preserved.
- `weightMemInput` retains its last contents outside WRITE. Consumers must only qualify it with `writeEn`.

## Timing
- Reset (sampled high at a rising edge): next cycle state=IDLE, rowCount=colCount=0, and all outputs 0:
  - `dataReady`, `writeEn`, `busy`, `loadDone`, `colAddressWrite`, `weightMemInput`.
- Reset has priority over everything, including mid-FILL and during WRITE:
  - The load is aborted and no further `writeEn` is issued.
  - Columns already written remain in the RAM.
- With `startLoad` sampled at edge 0 and `dataValid` held high:
  - FILL begins in cycle 1.
  - The WRITE for column c is in cycle (c+1)*(ROWS+1).
  - `loadDone` is high in cycle COLS*(ROWS+1)+1.
  - IDLE is re-entered in the following cycle.
- Each stall cycle (`dataValid`=0 in FILL) delays all subsequent events by exactly one cycle.
- `writeEn`, `colAddressWrite` and `weightMemInput` change together on the same edge. `weightRAM` samples them at the edge ending the WRITE cycle.
- Back-to-back loads: `startLoad` is accepted in the first IDLE cycle after DONE. The minimum gap between `loadDone` and the next FILL is 2 cycles.

## Test plan
- Continuous stream, ROWS=32, COLS=4, dataIn = 32*c + r:
  - `writeEn` pulses in cycles 33/66/99/132 with `colAddressWrite` 0/1/2/3.
  - `loadDone` in cycle 133.
  - Column 2 row 5 field = 69.
- Random `dataValid` gaps (~40% idle), same data: identical RAM contents. Each write occurs exactly (number of stall cycles so far) later than in the no-gap run.
- `startLoad` pulsed in cycle 10 of an active load: ignored. Exactly 4 writes and a single `loadDone`.
- Reset asserted at beat 10 of column 2:
  - Next cycle all outputs 0 and state IDLE; no further `writeEn`.
  - A fresh load then writes columns 0..3 correctly.
- Sign and range: stream 18'h3FFFF (-1 LSB), 18'h20000 (most negative) and 18'h1FFFF. All three are read back bit-exact through `weightRAM`.
- Integration, COLS=32, loading `weightRAM`(32,32,18): `colAddressRead` sweep 0..31 returns every column bit-exact. `dataValid` asserted in IDLE never sets `dataReady`.

Source files
------------

// File: rtl/weight_column_loader.sv
// weight_column_loader
// Collects a serial stream of fixed-point weights into full-width column words and writes
// them to a weightRAM, one column per write cycle, columns 0..COLS-1 in ascending order.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   startLoad        in   start a load of COLS columns (only honoured in idle)
//   dataIn           in   weight element, Q(QN).(QM) two's complement, forwarded bit-exact
//   dataValid        in   dataIn is valid this cycle
//   dataReady        out  element accepted this cycle when dataValid is also high
//   weightMemInput   out  assembled column, row r at [r*BITWIDTH +: BITWIDTH]
//   colAddressWrite  out  column address of the current write
//   writeEn          out  one-cycle write strobe
//   busy             out  high whenever a load is in progress
//   loadDone         out  one-cycle pulse after the last column is written
module weight_column_loader #(
    parameter int unsigned ROWS = 32,
    parameter int unsigned COLS = 4,
    parameter int unsigned QN   = 7,
    parameter int unsigned QM   = 10
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      startLoad,
    input  logic [QN+QM:0]                            dataIn,
    input  logic                                      dataValid,
    output logic                                      dataReady,
    output logic [ROWS*(QN+QM+1)-1:0]                 weightMemInput,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] colAddressWrite,
    output logic                                      writeEn,
    output logic                                      busy,
    output logic                                      loadDone
);

    localparam int unsigned BITWIDTH       = QN + QM + 1;
    localparam int unsigned LAYER_BITWIDTH = ROWS * BITWIDTH;
    localparam int unsigned ADDR_BITWIDTH  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_BITWIDTH   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ROW_BITWIDTH-1:0]  RowLast = ROW_BITWIDTH'(ROWS - 1);
    localparam logic [ADDR_BITWIDTH-1:0] ColLast = ADDR_BITWIDTH'(COLS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWrite,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [ROW_BITWIDTH-1:0]   row_q, row_d;
    logic [ADDR_BITWIDTH-1:0]  col_q, col_d;
    logic [LAYER_BITWIDTH-1:0] asm_q, asm_d;  // column under assembly

    // State and working registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            asm_q   <= asm_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        asm_d   = asm_q;
        unique case (state_q)
            StIdle: begin
                if (startLoad) begin
                    state_d = StFill;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StFill: begin
                if (dataValid) begin
                    for (int r = 0; r < int'(ROWS); r++) begin
                        if (row_q == ROW_BITWIDTH'(r)) begin
                            asm_d[r*BITWIDTH +: BITWIDTH] = dataIn;
                        end
                    end
                    if (row_q == RowLast) begin
                        row_d   = '0;
                        state_d = StWrite;
                    end else begin
                        row_d = row_q + ROW_BITWIDTH'(1);
                    end
                end
            end
            StWrite: begin
                if (col_q == ColLast) begin
                    state_d = StDone;
                end else begin
                    col_d   = col_q + ADDR_BITWIDTH'(1);
                    state_d = StFill;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    // The write bus is loaded only on entry to WRITE (including the final beat via asm_d), so
    // data, address and strobe all change on the same edge and hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            dataReady       <= 1'b0;
            busy            <= 1'b0;
            writeEn         <= 1'b0;
            loadDone        <= 1'b0;
            colAddressWrite <= '0;
            weightMemInput  <= '0;
        end else begin
            dataReady <= (state_d == StFill);
            busy      <= (state_d != StIdle);
            writeEn   <= (state_d == StWrite);
            loadDone  <= (state_d == StDone);
            if (state_d == StWrite) begin
                colAddressWrite <= col_q;
                weightMemInput  <= asm_d;
            end
        end
    end

endmodule

// File: tb/tb_weight_column_loader.sv
// Directed bench for weight_column_loader (ROWS=32, COLS=4, Q7.10).
// Expected column writes are queued as beats are driven and compared when writeEn appears.
module tb_weight_column_loader;

    localparam int ROWS = 32;
    localparam int COLS = 4;
    localparam int BW   = 18;
    localparam int LW   = ROWS * BW;
    localparam int AW   = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          startLoad;
    logic [BW-1:0] dataIn;
    logic          dataValid;
    logic          dataReady;
    logic [LW-1:0] weightMemInput;
    logic [AW-1:0] colAddressWrite;
    logic          writeEn;
    logic          busy;
    logic          loadDone;

    always #5 clock = ~clock;

    weight_column_loader #(
        .ROWS(ROWS),
        .COLS(COLS),
        .QN  (7),
        .QM  (10)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .startLoad      (startLoad),
        .dataIn         (dataIn),
        .dataValid      (dataValid),
        .dataReady      (dataReady),
        .weightMemInput (weightMemInput),
        .colAddressWrite(colAddressWrite),
        .writeEn        (writeEn),
        .busy           (busy),
        .loadDone       (loadDone)
    );

    typedef struct {
        int          addr;
        logic [LW-1:0] data;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  stalls   = 0;
    int  exp_done = -1;
    int  n_done   = 0;
    int  mode     = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge. Cycle number = edges since start.
    task automatic tick();
        wr_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (writeEn === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", writeEn, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", colAddressWrite, e.addr);
                chk("wr_data", weightMemInput, e.data);
                chk("wr_cycle", cyc, e.cyc);
                if (mode == 0 && e.addr == 2) chk("c2_r5", weightMemInput[5*BW +: BW], 69);
            end
        end
        if (loadDone === 1'b1) begin
            n_done++;
            chk("done_cycle", cyc, exp_done);
        end
    endtask

    function automatic logic [BW-1:0] gen(input int c, input int r);
        if (mode == 0) return BW'(32 * c + r);
        case (r % 4)
            0:       return 18'h3FFFF;
            1:       return 18'h20000;
            2:       return 18'h1FFFF;
            default: return BW'($urandom);
        endcase
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, dataReady, 1'b0);
        chk({tag, "_we"}, writeEn, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, loadDone, 1'b0);
        chk({tag, "_addr"}, colAddressWrite, '0);
        chk({tag, "_wmi"}, weightMemInput, '0);
    endtask

    // One full load. gap_pct: chance of a stall per FILL cycle. poke_cyc: cycle in which a
    // stray startLoad is driven. abort_col/abort_row: beat at which reset is asserted instead.
    task automatic run_load(input int gap_pct, input int poke_cyc,
                            input int abort_col, input int abort_row);
        logic [LW-1:0] col;
        logic [BW-1:0] d;
        logic          v;
        int            run;
        chk("idle_ready", dataReady, 1'b0);
        chk("idle_busy", busy, 1'b0);
        dataValid = 1'b1;
        dataIn    = BW'($urandom);
        startLoad = 1'b1;
        cyc       = 0;
        stalls    = 0;
        n_done    = 0;
        exp_done  = -1;
        tick();
        startLoad = 1'b0;
        chk("fill_busy", busy, 1'b1);
        for (int c = 0; c < COLS; c++) begin
            col = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (c == abort_col && r == abort_row) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    chk_all_zero("abort");
                    dataValid = 1'b1;
                    repeat (3) begin
                        tick();
                        chk("post_abort_we", writeEn, 1'b0);
                        chk("post_abort_ready", dataReady, 1'b0);
                    end
                    chk("abort_sb_empty", sb.size(), 0);
                    sb.delete();
                    return;
                end
                run = 0;
                do begin
                    chk("fill_ready", dataReady, 1'b1);
                    v = !(gap_pct > 0 && run < 8 && $urandom_range(99) < gap_pct);
                    d = v ? gen(c, r) : BW'($urandom);
                    dataValid = v;
                    dataIn    = d;
                    startLoad = (cyc == poke_cyc);
                    if (v) begin
                        col[r*BW +: BW] = d;
                        if (r == ROWS - 1) begin
                            sb.push_back('{c, col, (c + 1) * (ROWS + 1) + stalls});
                            if (c == COLS - 1) exp_done = COLS * (ROWS + 1) + 1 + stalls;
                        end
                    end
                    tick();
                    if (!v) begin
                        stalls++;
                        run++;
                    end
                end while (!v);
            end
            // WRITE cycle: offered data must be ignored
            chk("write_ready", dataReady, 1'b0);
            dataValid = 1'b1;
            dataIn    = BW'($urandom);
            startLoad = (cyc == poke_cyc);
            tick();
            startLoad = 1'b0;
        end
        chk("done_busy", busy, 1'b1);
        tick();
        chk("after_done_busy", busy, 1'b0);
        chk("after_done_ready", dataReady, 1'b0);
        chk("done_count", n_done, 1);
        chk("sb_empty", sb.size(), 0);
        dataValid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        startLoad = 1'b0;
        dataValid = 1'b0;
        dataIn    = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_all_zero("reset");
        // dataValid in idle must not raise dataReady
        dataValid = 1'b1;
        tick();
        chk("idle_valid_ready", dataReady, 1'b0);
        chk("idle_valid_busy", busy, 1'b0);

        mode = 0;
        run_load(0, -1, -1, -1);   // continuous stream, back-to-back with next
        run_load(40, -1, -1, -1);  // random stalls
        run_load(0, 10, -1, -1);   // stray startLoad mid-load
        run_load(0, -1, 2, 10);    // reset at beat 10 of column 2
        run_load(0, -1, -1, -1);   // fresh load after abort
        mode = 1;
        run_load(30, -1, -1, -1);  // sign / range extremes

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
